// File: rtl/dma_wr_arbiter.sv
// dma_wr_arbiter: shares one AXI4 write master between two DMA stream writers.
// AW is arbitrated per burst into a one-entry output register; W beats are steered
// in AW-grant order, and B responses are routed to the owner of the oldest burst.
// Build option: define DMA_ARB_FIXED_PRIO_EN for fixed priority (s0 always wins);
// the default build is round-robin.
module dma_wr_arbiter #(
  parameter int unsigned AXI_ID_WIDTH   = 6,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned ORDER_DEPTH    = 4,
  parameter int unsigned B_DEPTH        = 8
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  // writer 0
  input  logic [AXI_ID_WIDTH-1:0]     s0_axi_awid,
  input  logic [AXI_ADDR_WIDTH-1:0]   s0_axi_awaddr,
  input  logic [7:0]                  s0_axi_awlen,
  input  logic [2:0]                  s0_axi_awsize,
  input  logic [1:0]                  s0_axi_awburst,
  input  logic [3:0]                  s0_axi_awcache,
  input  logic                        s0_axi_awvalid,
  output logic                        s0_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   s0_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s0_axi_wstrb,
  input  logic                        s0_axi_wlast,
  input  logic                        s0_axi_wvalid,
  output logic                        s0_axi_wready,
  output logic                        s0_axi_bvalid,
  input  logic                        s0_axi_bready,
  // writer 1
  input  logic [AXI_ID_WIDTH-1:0]     s1_axi_awid,
  input  logic [AXI_ADDR_WIDTH-1:0]   s1_axi_awaddr,
  input  logic [7:0]                  s1_axi_awlen,
  input  logic [2:0]                  s1_axi_awsize,
  input  logic [1:0]                  s1_axi_awburst,
  input  logic [3:0]                  s1_axi_awcache,
  input  logic                        s1_axi_awvalid,
  output logic                        s1_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   s1_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s1_axi_wstrb,
  input  logic                        s1_axi_wlast,
  input  logic                        s1_axi_wvalid,
  output logic                        s1_axi_wready,
  output logic                        s1_axi_bvalid,
  input  logic                        s1_axi_bready,
  // merged master
  output logic [AXI_ID_WIDTH-1:0]     m_axi_awid,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                  m_axi_awlen,
  output logic [2:0]                  m_axi_awsize,
  output logic [1:0]                  m_axi_awburst,
  output logic [3:0]                  m_axi_awcache,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                        m_axi_wlast,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  // status
  output logic [$clog2(B_DEPTH):0]    sts_outstanding,
  output logic                        sts_orphan_b
);

  localparam int unsigned OP_W = $clog2(ORDER_DEPTH);
  localparam int unsigned BP_W = $clog2(B_DEPTH);
  localparam int unsigned OC_W = OP_W + 1;
  localparam int unsigned BC_W = BP_W + 1;

  // AW output register
  logic                      aw_valid_q;
  logic [AXI_ID_WIDTH-1:0]   aw_id_q;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_q;
  logic [7:0]                aw_len_q;
  logic [2:0]                aw_size_q;
  logic [1:0]                aw_burst_q;
  logic [3:0]                aw_cache_q;

  // W-order FIFO: one bit per granted burst (0 = s0, 1 = s1)
  logic [ORDER_DEPTH-1:0]    w_ord_q;
  logic [OP_W-1:0]           w_wr_q;
  logic [OP_W-1:0]           w_rd_q;
  logic [OC_W-1:0]           w_cnt_q;
  logic [OC_W-1:0]           w_cnt_d;

  // B-order FIFO
  logic [B_DEPTH-1:0]        b_ord_q;
  logic [BP_W-1:0]           b_wr_q;
  logic [BP_W-1:0]           b_rd_q;
  logic [BC_W-1:0]           b_cnt_q;
  logic [BC_W-1:0]           b_cnt_d;

  logic                      orphan_q;

  logic gnt0_c, gnt1_c;
  logic w_full_c, b_full_c, sel_ok_c, sel_c, sel_idx_c;
  logic w_head_c, w_empty_c, w_pop_c;
  logic b_head_c, b_empty_c, b_pop_c;

`ifdef DMA_ARB_FIXED_PRIO_EN
  // Fixed priority: s0 wins whenever it requests
  always_comb begin
    gnt0_c = s0_axi_awvalid;
    gnt1_c = s1_axi_awvalid & ~s0_axi_awvalid;
  end
`else
  logic rr_q;  // 1: s1 has priority on the next contested selection

  // Round-robin: on contention the writer not granted last time wins
  always_comb begin
    gnt0_c = s0_axi_awvalid;
    gnt1_c = s1_axi_awvalid;
    if (s0_axi_awvalid && s1_axi_awvalid) begin
      gnt0_c = ~rr_q;
      gnt1_c = rr_q;
    end
  end

  // Round-robin pointer flips priority to the writer just passed over
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rr_q <= 1'b0;
    end else if (sel_c) begin
      rr_q <= ~sel_idx_c;
    end
  end
`endif

  // Selection needs an empty AW register and room in both ordering FIFOs
  assign w_full_c       = (w_cnt_q == OC_W'(ORDER_DEPTH));
  assign b_full_c       = (b_cnt_q == BC_W'(B_DEPTH));
  assign sel_ok_c       = ~aw_valid_q & ~w_full_c & ~b_full_c;
  assign sel_c          = sel_ok_c & (gnt0_c | gnt1_c);
  assign sel_idx_c      = gnt1_c;
  assign s0_axi_awready = sel_ok_c & gnt0_c;
  assign s1_axi_awready = sel_ok_c & gnt1_c;

  // AW register: load on selection, drain on master handshake
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_valid_q <= 1'b0;
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      aw_cache_q <= '0;
    end else if (sel_c) begin
      aw_valid_q <= 1'b1;
      aw_id_q    <= sel_idx_c ? s1_axi_awid    : s0_axi_awid;
      aw_addr_q  <= sel_idx_c ? s1_axi_awaddr  : s0_axi_awaddr;
      aw_len_q   <= sel_idx_c ? s1_axi_awlen   : s0_axi_awlen;
      aw_size_q  <= sel_idx_c ? s1_axi_awsize  : s0_axi_awsize;
      aw_burst_q <= sel_idx_c ? s1_axi_awburst : s0_axi_awburst;
      aw_cache_q <= sel_idx_c ? s1_axi_awcache : s0_axi_awcache;
    end else if (m_axi_awready) begin
      aw_valid_q <= 1'b0;
    end
  end

  assign m_axi_awvalid = aw_valid_q;
  assign m_axi_awid    = aw_id_q;
  assign m_axi_awaddr  = aw_addr_q;
  assign m_axi_awlen   = aw_len_q;
  assign m_axi_awsize  = aw_size_q;
  assign m_axi_awburst = aw_burst_q;
  assign m_axi_awcache = aw_cache_q;

  // W steering from the head of the W-order FIFO
  assign w_empty_c     = (w_cnt_q == '0);
  assign w_head_c      = w_ord_q[w_rd_q];
  assign m_axi_wdata   = w_head_c ? s1_axi_wdata : s0_axi_wdata;
  assign m_axi_wstrb   = w_head_c ? s1_axi_wstrb : s0_axi_wstrb;
  assign m_axi_wlast   = w_head_c ? s1_axi_wlast : s0_axi_wlast;
  assign m_axi_wvalid  = ~w_empty_c & (w_head_c ? s1_axi_wvalid : s0_axi_wvalid);
  assign s0_axi_wready = ~w_empty_c & ~w_head_c & m_axi_wready;
  assign s1_axi_wready = ~w_empty_c &  w_head_c & m_axi_wready;
  assign w_pop_c       = m_axi_wvalid & m_axi_wready & m_axi_wlast;

  // B routing from the head of the B-order FIFO; empty FIFO swallows responses
  assign b_empty_c     = (b_cnt_q == '0);
  assign b_head_c      = b_ord_q[b_rd_q];
  assign s0_axi_bvalid = ~b_empty_c & ~b_head_c & m_axi_bvalid;
  assign s1_axi_bvalid = ~b_empty_c &  b_head_c & m_axi_bvalid;
  assign m_axi_bready  = b_empty_c | (b_head_c ? s1_axi_bready : s0_axi_bready);
  assign b_pop_c       = ~b_empty_c & m_axi_bvalid & m_axi_bready;

  // Occupancy next-state; simultaneous push and pop leave it unchanged
  always_comb begin
    w_cnt_d = w_cnt_q;
    b_cnt_d = b_cnt_q;
    case ({sel_c, w_pop_c})
      2'b10:   w_cnt_d = w_cnt_q + OC_W'(1);
      2'b01:   w_cnt_d = w_cnt_q - OC_W'(1);
      default: w_cnt_d = w_cnt_q;
    endcase
    case ({sel_c, b_pop_c})
      2'b10:   b_cnt_d = b_cnt_q + BC_W'(1);
      2'b01:   b_cnt_d = b_cnt_q - BC_W'(1);
      default: b_cnt_d = b_cnt_q;
    endcase
  end

  // W-order FIFO storage and pointers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_ord_q <= '0;
      w_wr_q  <= '0;
      w_rd_q  <= '0;
      w_cnt_q <= '0;
    end else begin
      if (sel_c) begin
        w_ord_q[w_wr_q] <= sel_idx_c;
        w_wr_q          <= w_wr_q + OP_W'(1);
      end
      if (w_pop_c) begin
        w_rd_q <= w_rd_q + OP_W'(1);
      end
      w_cnt_q <= w_cnt_d;
    end
  end

  // B-order FIFO storage and pointers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      b_ord_q <= '0;
      b_wr_q  <= '0;
      b_rd_q  <= '0;
      b_cnt_q <= '0;
    end else begin
      if (sel_c) begin
        b_ord_q[b_wr_q] <= sel_idx_c;
        b_wr_q          <= b_wr_q + BP_W'(1);
      end
      if (b_pop_c) begin
        b_rd_q <= b_rd_q + BP_W'(1);
      end
      b_cnt_q <= b_cnt_d;
    end
  end

  // Sticky flag for a B response arriving with nothing outstanding
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      orphan_q <= 1'b0;
    end else if (b_empty_c && m_axi_bvalid) begin
      orphan_q <= 1'b1;
    end
  end

  assign sts_outstanding = b_cnt_q;
  assign sts_orphan_b    = orphan_q;

endmodule

// File: tb/tb_dma_wr_arbiter.sv
// tb_dma_wr_arbiter: directed scenarios plus randomized traffic, every cycle
// compared against a queue-based reference model of the arbiter's rules.
module tb_dma_wr_arbiter;

  localparam int unsigned IW = 6;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned OD = 4;
  localparam int unsigned BD = 8;
`ifdef DMA_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [IW-1:0] s0_axi_awid, s1_axi_awid, m_axi_awid;
  logic [AW-1:0] s0_axi_awaddr, s1_axi_awaddr, m_axi_awaddr;
  logic [7:0]    s0_axi_awlen, s1_axi_awlen, m_axi_awlen;
  logic [2:0]    s0_axi_awsize, s1_axi_awsize, m_axi_awsize;
  logic [1:0]    s0_axi_awburst, s1_axi_awburst, m_axi_awburst;
  logic [3:0]    s0_axi_awcache, s1_axi_awcache, m_axi_awcache;
  logic          s0_axi_awvalid, s1_axi_awvalid, m_axi_awvalid;
  logic          s0_axi_awready, s1_axi_awready, m_axi_awready;
  logic [DW-1:0] s0_axi_wdata, s1_axi_wdata, m_axi_wdata;
  logic [SW-1:0] s0_axi_wstrb, s1_axi_wstrb, m_axi_wstrb;
  logic          s0_axi_wlast, s1_axi_wlast, m_axi_wlast;
  logic          s0_axi_wvalid, s1_axi_wvalid, m_axi_wvalid;
  logic          s0_axi_wready, s1_axi_wready, m_axi_wready;
  logic          s0_axi_bvalid, s1_axi_bvalid, m_axi_bvalid;
  logic          s0_axi_bready, s1_axi_bready, m_axi_bready;
  logic [3:0]    sts_outstanding;
  logic          sts_orphan_b;

  dma_wr_arbiter #(
    .AXI_ID_WIDTH(IW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
    .ORDER_DEPTH(OD), .B_DEPTH(BD)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s0_axi_awid(s0_axi_awid), .s0_axi_awaddr(s0_axi_awaddr), .s0_axi_awlen(s0_axi_awlen),
    .s0_axi_awsize(s0_axi_awsize), .s0_axi_awburst(s0_axi_awburst), .s0_axi_awcache(s0_axi_awcache),
    .s0_axi_awvalid(s0_axi_awvalid), .s0_axi_awready(s0_axi_awready),
    .s0_axi_wdata(s0_axi_wdata), .s0_axi_wstrb(s0_axi_wstrb), .s0_axi_wlast(s0_axi_wlast),
    .s0_axi_wvalid(s0_axi_wvalid), .s0_axi_wready(s0_axi_wready),
    .s0_axi_bvalid(s0_axi_bvalid), .s0_axi_bready(s0_axi_bready),
    .s1_axi_awid(s1_axi_awid), .s1_axi_awaddr(s1_axi_awaddr), .s1_axi_awlen(s1_axi_awlen),
    .s1_axi_awsize(s1_axi_awsize), .s1_axi_awburst(s1_axi_awburst), .s1_axi_awcache(s1_axi_awcache),
    .s1_axi_awvalid(s1_axi_awvalid), .s1_axi_awready(s1_axi_awready),
    .s1_axi_wdata(s1_axi_wdata), .s1_axi_wstrb(s1_axi_wstrb), .s1_axi_wlast(s1_axi_wlast),
    .s1_axi_wvalid(s1_axi_wvalid), .s1_axi_wready(s1_axi_wready),
    .s1_axi_bvalid(s1_axi_bvalid), .s1_axi_bready(s1_axi_bready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awcache(m_axi_awcache),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .sts_outstanding(sts_outstanding), .sts_orphan_b(sts_orphan_b)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending AW burst, ordering queues, priority and orphan flag
  bit            m_pend;
  logic [IW-1:0] m_id;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_len;
  logic [2:0]    m_size;
  logic [1:0]    m_burst;
  logic [3:0]    m_cache;
  bit            m_s1_first;
  bit            m_orphan;
  int            m_wq[$];
  int            m_bq[$];
  int            obs_gnt[$];

  task automatic model_clear();
    m_pend = 1'b0;
    m_s1_first = 1'b0;
    m_orphan = 1'b0;
    m_wq.delete();
    m_bq.delete();
    obs_gnt.delete();
  endtask

  task automatic idle();
    s0_axi_awvalid = 0; s1_axi_awvalid = 0;
    s0_axi_awid = '0; s1_axi_awid = '0; s0_axi_awaddr = '0; s1_axi_awaddr = '0;
    s0_axi_awlen = '0; s1_axi_awlen = '0; s0_axi_awsize = 3'd3; s1_axi_awsize = 3'd3;
    s0_axi_awburst = 2'd1; s1_axi_awburst = 2'd1; s0_axi_awcache = 4'd3; s1_axi_awcache = 4'd3;
    s0_axi_wdata = '0; s1_axi_wdata = '0; s0_axi_wstrb = '1; s1_axi_wstrb = '1;
    s0_axi_wlast = 0; s1_axi_wlast = 0; s0_axi_wvalid = 0; s1_axi_wvalid = 0;
    s0_axi_bready = 1; s1_axi_bready = 1;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
  endtask

  // Assert reset asynchronously, check the cleared outputs, release off-edge
  task automatic do_reset();
    aresetn = 1'b0;
    #1;
    model_clear();
    check("rst_awvalid", 64'(m_axi_awvalid), 64'(0));
    check("rst_wvalid", 64'(m_axi_wvalid), 64'(0));
    check("rst_outstanding", 64'(sts_outstanding), 64'(0));
    check("rst_orphan", 64'(sts_orphan_b), 64'(0));
    @(posedge aclk);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  // One cycle: compare all outputs against the model, clock, then advance the model
  task automatic step();
    bit sel_ok, g0, g1, e_wv, e_wl, e_br;
    logic [DW-1:0] e_wd;
    logic [SW-1:0] e_ws;
    int h, g;
    #1;
    sel_ok = !m_pend && (m_wq.size() < OD) && (m_bq.size() < BD);
    if (FIXED) begin
      g0 = s0_axi_awvalid;
      g1 = s1_axi_awvalid && !s0_axi_awvalid;
    end else begin
      g0 = s0_axi_awvalid && !(s1_axi_awvalid && m_s1_first);
      g1 = s1_axi_awvalid && !(s0_axi_awvalid && !m_s1_first);
    end
    g0 = g0 && sel_ok;
    g1 = g1 && sel_ok;
    check("s0_awready", 64'(s0_axi_awready), 64'(g0));
    check("s1_awready", 64'(s1_axi_awready), 64'(g1));
    if (s0_axi_awready === 1'b1) obs_gnt.push_back(0);
    if (s1_axi_awready === 1'b1) obs_gnt.push_back(1);

    check("m_awvalid", 64'(m_axi_awvalid), 64'(m_pend));
    if (m_pend) begin
      check("m_awaddr", 64'(m_axi_awaddr), 64'(m_addr));
      check("m_awid", 64'(m_axi_awid), 64'(m_id));
      check("m_awlen", 64'(m_axi_awlen), 64'(m_len));
      check("m_awsize", 64'(m_axi_awsize), 64'(m_size));
      check("m_awburst", 64'(m_axi_awburst), 64'(m_burst));
      check("m_awcache", 64'(m_axi_awcache), 64'(m_cache));
    end

    e_wv = 1'b0; e_wl = 1'b0; e_wd = '0; e_ws = '0; h = 0;
    if (m_wq.size() == 0) begin
      check("m_wvalid_empty", 64'(m_axi_wvalid), 64'(0));
      check("s0_wready_empty", 64'(s0_axi_wready), 64'(0));
      check("s1_wready_empty", 64'(s1_axi_wready), 64'(0));
    end else begin
      h = m_wq[0];
      if (h == 0) begin
        e_wv = s0_axi_wvalid; e_wl = s0_axi_wlast; e_wd = s0_axi_wdata; e_ws = s0_axi_wstrb;
      end else begin
        e_wv = s1_axi_wvalid; e_wl = s1_axi_wlast; e_wd = s1_axi_wdata; e_ws = s1_axi_wstrb;
      end
      check("m_wvalid", 64'(m_axi_wvalid), 64'(e_wv));
      check("m_wdata", m_axi_wdata, e_wd);
      check("m_wstrb", 64'(m_axi_wstrb), 64'(e_ws));
      check("m_wlast", 64'(m_axi_wlast), 64'(e_wl));
      check("s0_wready", 64'(s0_axi_wready), 64'((h == 0) && m_axi_wready));
      check("s1_wready", 64'(s1_axi_wready), 64'((h == 1) && m_axi_wready));
    end

    e_br = 1'b1; g = 0;
    if (m_bq.size() != 0) begin
      g = m_bq[0];
      e_br = (g == 0) ? s0_axi_bready : s1_axi_bready;
    end
    check("m_bready", 64'(m_axi_bready), 64'(e_br));
    check("s0_bvalid", 64'(s0_axi_bvalid), 64'((m_bq.size() != 0) && (g == 0) && m_axi_bvalid));
    check("s1_bvalid", 64'(s1_axi_bvalid), 64'((m_bq.size() != 0) && (g == 1) && m_axi_bvalid));
    check("outstanding", 64'(sts_outstanding), 64'(m_bq.size()));
    check("orphan", 64'(sts_orphan_b), 64'(m_orphan));

    @(posedge aclk);
    if (m_wq.size() != 0 && e_wv && m_axi_wready && e_wl) void'(m_wq.pop_front());
    if (m_bq.size() != 0) begin
      if (m_axi_bvalid && e_br) void'(m_bq.pop_front());
    end else if (m_axi_bvalid) begin
      m_orphan = 1'b1;
    end
    if (m_pend && m_axi_awready) m_pend = 1'b0;
    if (g0 || g1) begin
      m_pend  = 1'b1;
      m_id    = g1 ? s1_axi_awid    : s0_axi_awid;
      m_addr  = g1 ? s1_axi_awaddr  : s0_axi_awaddr;
      m_len   = g1 ? s1_axi_awlen   : s0_axi_awlen;
      m_size  = g1 ? s1_axi_awsize  : s0_axi_awsize;
      m_burst = g1 ? s1_axi_awburst : s0_axi_awburst;
      m_cache = g1 ? s1_axi_awcache : s0_axi_awcache;
      m_wq.push_back(g1 ? 1 : 0);
      m_bq.push_back(g1 ? 1 : 0);
      m_s1_first = g0;
    end
    #1;
  endtask

  initial begin
    idle();
    do_reset();

    // Single s0 burst of 16 beats, one B back to s0
    idle();
    s0_axi_awaddr = 32'h1000; s0_axi_awlen = 8'd15; s0_axi_awid = 6'd5;
    s0_axi_awvalid = 1; m_axi_awready = 1;
    s1_axi_wvalid = 1; s1_axi_wdata = 64'hdead_beef_0000_0001;
    step();
    check("t1_grant_cnt", 64'(obs_gnt.size()), 64'(1));
    s0_axi_awvalid = 0;
    m_axi_wready = 1;
    for (int i = 0; i < 16; i++) begin
      s0_axi_wvalid = 1; s0_axi_wdata = {32'h0a0a_0a0a, 32'(i)}; s0_axi_wlast = (i == 15);
      if (i == 0) check("t1_awaddr", 64'(m_axi_awaddr), 64'(32'h1000));
      step();
    end
    s0_axi_wvalid = 0; s0_axi_wlast = 0;
    check("t1_out_before_b", 64'(sts_outstanding), 64'(1));
    m_axi_bvalid = 1;
    step();
    m_axi_bvalid = 0;
    check("t1_out_after_b", 64'(sts_outstanding), 64'(0));

    // Both writers request continuously; B held off until the B-order FIFO fills
    do_reset();
    idle();
    s0_axi_awvalid = 1; s1_axi_awvalid = 1;
    s0_axi_awaddr = 32'h2000; s1_axi_awaddr = 32'h3000; s1_axi_awid = 6'd9;
    s0_axi_wvalid = 1; s1_axi_wvalid = 1; s0_axi_wlast = 1; s1_axi_wlast = 1;
    s0_axi_wdata = 64'h1111; s1_axi_wdata = 64'h2222;
    m_axi_awready = 1; m_axi_wready = 1;
    repeat (24) step();
    check("t3_grants_at_stall", 64'(obs_gnt.size()), 64'(8));
    for (int i = 0; i < obs_gnt.size(); i++)
      check("t2_grant_order", 64'(obs_gnt[i]), FIXED ? 64'(0) : 64'(i % 2));
    check("t3_s0_awready_stall", 64'(s0_axi_awready), 64'(0));
    check("t3_s1_awready_stall", 64'(s1_axi_awready), 64'(0));
    m_axi_bvalid = 1;
    step();
    m_axi_bvalid = 0;
    repeat (4) step();
    check("t3_ninth_grant", 64'(obs_gnt.size()), 64'(9));
    if (obs_gnt.size() > 8) check("t3_ninth_src", 64'(obs_gnt[8]), 64'(0));

    // W path blocked: W-order FIFO limits grants, one wlast releases one more
    do_reset();
    idle();
    s0_axi_awvalid = 1; s1_axi_awvalid = 1;
    s0_axi_wvalid = 1; s1_axi_wvalid = 1; s0_axi_wlast = 1; s1_axi_wlast = 1;
    m_axi_awready = 1;
    repeat (16) step();
    check("t4_grants_stalled", 64'(obs_gnt.size()), 64'(OD));
    m_axi_wready = 1;
    step();
    m_axi_wready = 0;
    repeat (4) step();
    check("t4_grants_resumed", 64'(obs_gnt.size()), 64'(OD + 1));

    // Orphan B response
    do_reset();
    idle();
    m_axi_bvalid = 1;
    step();
    m_axi_bvalid = 0;
    check("t5_orphan_set", 64'(sts_orphan_b), 64'(1));
    repeat (3) step();
    check("t5_orphan_sticky", 64'(sts_orphan_b), 64'(1));

    // Reset in the middle of a burst
    do_reset();
    idle();
    s0_axi_awvalid = 1; s0_axi_awaddr = 32'h4000; s0_axi_awlen = 8'd15;
    step();
    s0_axi_awvalid = 0;
    s0_axi_wvalid = 1; m_axi_wready = 1;
    repeat (4) step();
    #1;
    check("t6_pre_awvalid", 64'(m_axi_awvalid), 64'(1));
    check("t6_pre_wvalid", 64'(m_axi_wvalid), 64'(1));
    check("t6_pre_outstanding", 64'(sts_outstanding), 64'(1));
    do_reset();

    // Randomized traffic against the model
    idle();
    for (int c = 0; c < 3000; c++) begin
      s0_axi_awvalid = ($urandom_range(0, 2) != 0);
      s1_axi_awvalid = ($urandom_range(0, 2) != 0);
      s0_axi_awid = IW'($urandom); s1_axi_awid = IW'($urandom);
      s0_axi_awaddr = $urandom; s1_axi_awaddr = $urandom;
      s0_axi_awlen = 8'($urandom); s1_axi_awlen = 8'($urandom);
      s0_axi_awsize = 3'($urandom); s1_axi_awsize = 3'($urandom);
      s0_axi_awburst = 2'($urandom); s1_axi_awburst = 2'($urandom);
      s0_axi_awcache = 4'($urandom); s1_axi_awcache = 4'($urandom);
      s0_axi_wdata = {$urandom, $urandom}; s1_axi_wdata = {$urandom, $urandom};
      s0_axi_wstrb = SW'($urandom); s1_axi_wstrb = SW'($urandom);
      s0_axi_wvalid = ($urandom_range(0, 3) != 0); s1_axi_wvalid = ($urandom_range(0, 3) != 0);
      s0_axi_wlast = ($urandom_range(0, 2) == 0); s1_axi_wlast = ($urandom_range(0, 2) == 0);
      s0_axi_bready = ($urandom_range(0, 3) != 0); s1_axi_bready = ($urandom_range(0, 3) != 0);
      m_axi_awready = ($urandom_range(0, 2) != 0);
      m_axi_wready = ($urandom_range(0, 2) != 0);
      m_axi_bvalid = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
